// File: rtl/ex_issue_stage.sv
// ex_issue_stage: ID->EX issue register resolving ALU operands; RAW forwarding and stall snoop when EX_FWD_EN is defined
module ex_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            fwd_exmem_we,
  input  logic [4:0]      fwd_exmem_rd,
  input  logic [XLEN-1:0] fwd_exmem_data,
  input  logic            fwd_memwb_we,
  input  logic [4:0]      fwd_memwb_rd,
  input  logic [XLEN-1:0] fwd_memwb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [3:0]      alu_ctrl,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic accept;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt, rs1_val, rs2_val;
  logic [XLEN-1:0] d_in1, d_in2;
  logic [3:0] d_ctrl;
  logic d_use1, d_use2, d_we, d_ill;
  assign opcode = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign rd = in_instr[11:7];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'h000}));
  assign shamt = XLEN'(in_instr[24:20]);
  assign accept = in_valid && in_ready && !flush;
  function automatic logic [3:0] alu_op(input logic [2:0] f, input logic alt);
    return f == 3'b000 ? {3'b000, alt} :
           f == 3'b001 ? 4'd5 :
           f == 3'b010 ? 4'd8 :
           f == 3'b011 ? 4'd9 :
           f == 3'b100 ? 4'd4 :
           f == 3'b101 ? {3'b011, alt} :
           f == 3'b110 ? 4'd3 : 4'd2;
  endfunction
`ifdef EX_FWD_EN
  logic [4:0] rs1_q, rs2_q;
  logic use1_q, use2_q;
  function automatic logic [XLEN-1:0] fwd(input logic [4:0] rs, input logic [XLEN-1:0] dflt);
    return rs == 5'd0 ? dflt :
           (fwd_exmem_we && fwd_exmem_rd == rs) ? fwd_exmem_data :
           (fwd_memwb_we && fwd_memwb_rd == rs) ? fwd_memwb_data : dflt;
  endfunction
  assign rs1_val = fwd(rs1, in_rs1_data);
  assign rs2_val = fwd(rs2, in_rs2_data);
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_exmem_we, fwd_exmem_rd, fwd_exmem_data, fwd_memwb_we, fwd_memwb_rd, fwd_memwb_data, rs1, rs2, d_use1, d_use2};
  assign rs1_val = in_rs1_data;
  assign rs2_val = in_rs2_data;
`endif
  // decode opcode into operands, ALU op and register-operand flags
  always_comb begin
    d_in1 = '0;
    d_in2 = '0;
    d_ctrl = 4'd0;
    d_use1 = 1'b0;
    d_use2 = 1'b0;
    d_we = rd != 5'd0;
    d_ill = 1'b0;
    case (opcode)
      7'b0110011: begin
        d_in1 = rs1_val;
        d_in2 = rs2_val;
        d_use1 = 1'b1;
        d_use2 = 1'b1;
        d_ctrl = alu_op(f3, in_instr[30]);
      end
      7'b0010011: begin
        d_in1 = rs1_val;
        d_use1 = 1'b1;
        d_in2 = f3[1:0] == 2'b01 ? shamt : imm_i;
        d_ctrl = alu_op(f3, in_instr[30] && f3 == 3'b101);
      end
      7'b0000011: begin
        d_in1 = rs1_val;
        d_use1 = 1'b1;
        d_in2 = imm_i;
      end
      7'b0100011: begin
        d_in1 = rs1_val;
        d_use1 = 1'b1;
        d_in2 = imm_s;
        d_we = 1'b0;
      end
      7'b1100011: begin
        d_in1 = rs1_val;
        d_in2 = rs2_val;
        d_use1 = 1'b1;
        d_use2 = 1'b1;
        d_we = 1'b0;
        d_ctrl = !f3[2] ? 4'd1 : f3[1] ? 4'd9 : 4'd8;
      end
      7'b0110111: d_in2 = imm_u;
      7'b0010111: begin
        d_in1 = in_pc;
        d_in2 = imm_u;
      end
      7'b1101111, 7'b1100111: begin
        d_in1 = in_pc;
        d_in2 = XLEN'(4);
      end
      default: begin
        d_we = 1'b0;
        d_ill = 1'b1;
      end
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else state <= state_nx;
  end
  // next state: flush wins, then accept, then hold while stalled
  always_comb begin
    state_nx = flush ? EMPTY : accept ? FULL : (state == FULL && !out_ready) ? FULL : EMPTY;
  end
  // handshake outputs
  always_comb begin
    out_valid = state == FULL;
    in_ready = !out_valid || out_ready;
  end
  // capture decoded instruction; re-resolve held register operands while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_ctrl <= 4'd0;
      out_rd <= 5'd0;
      out_rd_we <= 1'b0;
      out_pc <= '0;
      out_illegal <= 1'b0;
`ifdef EX_FWD_EN
      rs1_q <= 5'd0;
      rs2_q <= 5'd0;
      use1_q <= 1'b0;
      use2_q <= 1'b0;
`endif
    end else if (accept) begin
      alu_in1 <= d_in1;
      alu_in2 <= d_in2;
      alu_ctrl <= d_ctrl;
      out_rd <= rd;
      out_rd_we <= d_we;
      out_pc <= in_pc;
      out_illegal <= d_ill;
`ifdef EX_FWD_EN
      rs1_q <= rs1;
      rs2_q <= rs2;
      use1_q <= d_use1;
      use2_q <= d_use2;
`endif
    end
`ifdef EX_FWD_EN
    else if (out_valid && !out_ready && !flush) begin
      alu_in1 <= use1_q ? fwd(rs1_q, alu_in1) : alu_in1;
      alu_in2 <= use2_q ? fwd(rs2_q, alu_in2) : alu_in2;
    end
`endif
  end
endmodule

// File: tb/tb_ex_issue_stage.sv
// tb_ex_issue_stage: directed and randomized checks of ex_issue_stage against a behavioural model
module tb_ex_issue_stage;
`ifdef EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct packed {
    logic v;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0] ctrl;
    logic [4:0] rd;
    logic we;
    logic [31:0] pc;
    logic ill;
  } obs_t;
  logic clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic fwd_exmem_we, fwd_memwb_we;
  logic [4:0] fwd_exmem_rd, fwd_memwb_rd;
  logic [31:0] fwd_exmem_data, fwd_memwb_data;
  logic [31:0] alu_in1, alu_in2, out_pc;
  logic [3:0] alu_ctrl;
  logic [4:0] out_rd;
  logic out_rd_we, out_illegal;
  obs_t obs;
  int n_cmp = 0;
  int n_err = 0;
  ex_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .fwd_exmem_we(fwd_exmem_we), .fwd_exmem_rd(fwd_exmem_rd), .fwd_exmem_data(fwd_exmem_data),
    .fwd_memwb_we(fwd_memwb_we), .fwd_memwb_rd(fwd_memwb_rd), .fwd_memwb_data(fwd_memwb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_pc(out_pc), .out_illegal(out_illegal)
  );
  assign obs = {out_valid, alu_in1, alu_in2, alu_ctrl, out_rd, out_rd_we, out_pc, out_illegal};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [31:0] mfwd(input logic [4:0] rs, input logic [31:0] d);
    if (FWD && rs != 5'd0) begin
      if (fwd_exmem_we && fwd_exmem_rd == rs) return fwd_exmem_data;
      if (fwd_memwb_we && fwd_memwb_rd == rs) return fwd_memwb_data;
    end
    return d;
  endfunction
  function automatic logic reads_rs1(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
  endfunction
  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h63};
  endfunction
  function automatic obs_t model(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2);
    logic [3:0] base [8];
    logic [2:0] f3;
    logic [31:0] a, b, ii, si, ui;
    obs_t e;
    base = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    f3 = i[14:12];
    a = mfwd(i[19:15], d1);
    b = mfwd(i[24:20], d2);
    ii = {{20{i[31]}}, i[31:20]};
    si = {{20{i[31]}}, i[31:25], i[11:7]};
    ui = {i[31:12], 12'h000};
    e = '{v: 1'b1, in1: 32'd0, in2: 32'd0, ctrl: 4'd0, rd: i[11:7], we: i[11:7] != 5'd0, pc: pc, ill: 1'b0};
    case (i[6:0])
      7'h33: begin
        e.in1 = a;
        e.in2 = b;
        e.ctrl = base[f3] + {3'b000, (f3 == 3'd0 || f3 == 3'd5) && i[30]};
      end
      7'h13: begin
        e.in1 = a;
        e.in2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, i[24:20]} : ii;
        e.ctrl = base[f3] + {3'b000, f3 == 3'd5 && i[30]};
      end
      7'h03: begin
        e.in1 = a;
        e.in2 = ii;
      end
      7'h23: begin
        e.in1 = a;
        e.in2 = si;
        e.we = 1'b0;
      end
      7'h63: begin
        e.in1 = a;
        e.in2 = b;
        e.we = 1'b0;
        e.ctrl = f3 < 3'd4 ? 4'd1 : f3 < 3'd6 ? 4'd8 : 4'd9;
      end
      7'h37: e.in2 = ui;
      7'h17: begin
        e.in1 = pc;
        e.in2 = ui;
      end
      7'h6F, 7'h67: begin
        e.in1 = pc;
        e.in2 = 32'd4;
      end
      default: begin
        e.we = 1'b0;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction
  function automatic obs_t snoop(input obs_t e, input logic [31:0] i);
    if (reads_rs1(i[6:0])) e.in1 = mfwd(i[19:15], e.in1);
    if (reads_rs2(i[6:0])) e.in2 = mfwd(i[24:20], e.in2);
    return e;
  endfunction
  function automatic logic [31:0] gen_instr();
    logic [6:0] ops [10];
    logic [31:0] i;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
    i = $urandom;
    i[6:0] = ops[$urandom_range(0, 9)];
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    if (i[6:0] == 7'h63 && !i[14]) i[13] = 1'b0;
    return i;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    in_instr = 32'd0;
    in_pc = 32'd0;
    in_rs1_data = 32'd0;
    in_rs2_data = 32'd0;
    fwd_exmem_we = 1'b0;
    fwd_exmem_rd = 5'd0;
    fwd_exmem_data = 32'd0;
    fwd_memwb_we = 1'b0;
    fwd_memwb_rd = 5'd0;
    fwd_memwb_data = 32'd0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    in_valid = 1'b1;
    in_instr = 32'h002081B3;
    tick();
    tick();
    n_cmp++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic test_add();
    obs_t e;
    idle();
    in_valid = 1'b1;
    in_instr = 32'h002081B3;
    in_pc = 32'h40;
    in_rs1_data = 32'd5;
    in_rs2_data = 32'd7;
    e = '{1'b1, 32'd5, 32'd7, 4'd0, 5'd3, 1'b1, 32'h40, 1'b0};
    tick();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL add: got %h want %h", obs, e);
    end
    in_valid = 1'b0;
    tick();
    e.v = 1'b0;
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL add_hold_empty: got %h want %h", obs, e);
    end
  endtask
  task automatic test_fwd_priority();
    obs_t e;
    idle();
    in_valid = 1'b1;
    in_instr = 32'h402082B3;
    in_pc = 32'h44;
    in_rs1_data = 32'd1;
    in_rs2_data = 32'd2;
    fwd_exmem_we = 1'b1;
    fwd_exmem_rd = 5'd1;
    fwd_exmem_data = 32'd100;
    fwd_memwb_we = 1'b1;
    fwd_memwb_rd = 5'd1;
    fwd_memwb_data = 32'd50;
    e = '{1'b1, FWD ? 32'd100 : 32'd1, 32'd2, 4'd1, 5'd5, 1'b1, 32'h44, 1'b0};
    tick();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL fwd_exmem_priority: got %h want %h", obs, e);
    end
    fwd_exmem_we = 1'b0;
    e.in1 = FWD ? 32'd50 : 32'd1;
    tick();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL fwd_memwb: got %h want %h", obs, e);
    end
    fwd_exmem_we = 1'b1;
    fwd_exmem_rd = 5'd0;
    fwd_memwb_rd = 5'd0;
    e.in1 = 32'd1;
    tick();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL fwd_rd0_none: got %h want %h", obs, e);
    end
    idle();
    tick();
  endtask
  task automatic test_stall_snoop();
    obs_t e1, e2;
    idle();
    in_valid = 1'b1;
    in_instr = 32'h40335213;
    in_pc = 32'h58;
    in_rs1_data = 32'h11;
    e1 = '{1'b1, 32'h11, 32'd3, 4'd7, 5'd4, 1'b1, 32'h58, 1'b0};
    tick();
    n_cmp++;
    if (obs !== e1) begin
      n_err++;
      $display("FAIL srai_accept: got %h want %h", obs, e1);
    end
    in_instr = 32'h002081B3;
    in_pc = 32'h60;
    in_rs1_data = 32'd5;
    in_rs2_data = 32'd7;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        fwd_memwb_we = 1'b1;
        fwd_memwb_rd = 5'd6;
        fwd_memwb_data = 32'h80000000;
      end else begin
        fwd_memwb_we = 1'b0;
      end
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_in_ready cycle %0d: got %b want 0", c, in_ready);
      end
      tick();
      if (c == 1 && FWD) e1.in1 = 32'h80000000;
      n_cmp++;
      if (obs !== e1) begin
        n_err++;
        $display("FAIL stall_snoop cycle %0d: got %h want %h", c, obs, e1);
      end
    end
    fwd_memwb_we = 1'b0;
    out_ready = 1'b1;
    e2 = '{1'b1, 32'd5, 32'd7, 4'd0, 5'd3, 1'b1, 32'h60, 1'b0};
    tick();
    n_cmp++;
    if (obs !== e2) begin
      n_err++;
      $display("FAIL stall_release: got %h want %h", obs, e2);
    end
    idle();
    tick();
  endtask
  task automatic test_flush();
    idle();
    tick();
    in_valid = 1'b1;
    in_instr = 32'h002081B3;
    flush = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_accept: got valid %b want 0", out_valid);
    end
    flush = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL flush_then_accept: got valid %b want 1", out_valid);
    end
    flush = 1'b1;
    out_ready = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_full: got valid %b want 0", out_valid);
    end
    idle();
  endtask
  task automatic test_decode();
    logic [31:0] ins [7];
    logic [31:0] pcs [7];
    obs_t ex [7];
    ins = '{32'h123453B7, 32'h00001417, 32'h0020E063, 32'h000001FF, 32'h000000EF, 32'hFE20AFA3, 32'hFFF08013};
    pcs = '{32'h10, 32'h100, 32'h20, 32'h30, 32'h200, 32'h40, 32'h50};
    ex[0] = '{1'b1, 32'h0, 32'h12345000, 4'd0, 5'd7, 1'b1, 32'h10, 1'b0};
    ex[1] = '{1'b1, 32'h100, 32'h1000, 4'd0, 5'd8, 1'b1, 32'h100, 1'b0};
    ex[2] = '{1'b1, 32'hAAAA, 32'hBBBB, 4'd9, 5'd0, 1'b0, 32'h20, 1'b0};
    ex[3] = '{1'b1, 32'h0, 32'h0, 4'd0, 5'd3, 1'b0, 32'h30, 1'b1};
    ex[4] = '{1'b1, 32'h200, 32'd4, 4'd0, 5'd1, 1'b1, 32'h200, 1'b0};
    ex[5] = '{1'b1, 32'hAAAA, 32'hFFFFFFFF, 4'd0, 5'd31, 1'b0, 32'h40, 1'b0};
    ex[6] = '{1'b1, 32'hAAAA, 32'hFFFFFFFF, 4'd0, 5'd0, 1'b0, 32'h50, 1'b0};
    idle();
    in_valid = 1'b1;
    in_rs1_data = 32'hAAAA;
    in_rs2_data = 32'hBBBB;
    for (int k = 0; k < 7; k++) begin
      in_instr = ins[k];
      in_pc = pcs[k];
      tick();
      n_cmp++;
      if (obs !== ex[k]) begin
        n_err++;
        $display("FAIL decode_%0d: got %h want %h", k, obs, ex[k]);
      end
    end
    idle();
    tick();
  endtask
  task automatic test_back_to_back();
    obs_t e;
    int nv;
    nv = 0;
    idle();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_instr = gen_instr();
      in_pc = $urandom;
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      e = model(in_instr, in_pc, in_rs1_data, in_rs2_data);
      tick();
      nv += int'(out_valid);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL b2b_%0d: got %h want %h", k, obs, e);
      end
    end
    n_cmp++;
    if (nv != 4) begin
      n_err++;
      $display("FAIL b2b_valid_count: got %0d want 4", nv);
    end
    in_instr = gen_instr();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_mid_async: got %h want 0", obs);
    end
    tick();
    n_cmp++;
    if (obs !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_hold: got %h ready %b want 0 ready 1", obs, in_ready);
    end
    rst_n = 1'b1;
    idle();
  endtask
  task automatic test_random();
    obs_t cur, nxt;
    logic [31:0] cur_i, ni;
    logic rdy, acc;
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
    cur = '0;
    cur_i = 32'd0;
    for (int c = 0; c < 400; c++) begin
      ni = gen_instr();
      in_instr = ni;
      in_pc = $urandom;
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      fwd_exmem_we = 1'($urandom);
      fwd_exmem_rd = 5'($urandom_range(0, 7));
      fwd_exmem_data = $urandom;
      fwd_memwb_we = 1'($urandom);
      fwd_memwb_rd = 5'($urandom_range(0, 7));
      fwd_memwb_data = $urandom;
      #1;
      rdy = !cur.v || out_ready;
      acc = in_valid && rdy && !flush;
      n_cmp++;
      if (in_ready !== rdy) begin
        n_err++;
        $display("FAIL rand_in_ready cycle %0d: got %b want %b", c, in_ready, rdy);
      end
      if (acc) nxt = model(ni, in_pc, in_rs1_data, in_rs2_data);
      else begin
        nxt = cur;
        if (cur.v && !out_ready && !flush) nxt = snoop(cur, cur_i);
        nxt.v = cur.v && !out_ready && !flush;
      end
      tick();
      n_cmp++;
      if (obs !== nxt) begin
        n_err++;
        $display("FAIL rand_out cycle %0d: got %h want %h", c, obs, nxt);
      end
      if (acc) cur_i = ni;
      cur = nxt;
    end
    idle();
  endtask
  initial begin
    test_reset();
    test_add();
    test_fwd_priority();
    test_stall_snoop();
    test_flush();
    test_decode();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
